// File: rtl/value_entry_pkg.sv
// Shared definitions for the value_entry block: FSM state encoding,
// the hex digit limit and the default operand width.
package value_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int unsigned HEX_DIGIT_LIMIT = 4;
  localparam int unsigned VALUE_W_DEFAULT = 14;

endpackage

// File: rtl/value_entry_key_debounce.sv
// key_debounce: conditions one raw asynchronous push button.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   btn_i   - raw button level, active-high
//   rise_o  - one-cycle pulse on the debounced rising edge
// The input passes a 2-flop synchronizer; the debounced level follows the
// synchronized level only after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q, s2_q;
  logic [1:0]       fill_q;
  logic             armed_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise_q;

  // Until the synchronizer holds a real sample (fill_q[1]), the debounced
  // level is not trusted. The first real sample is adopted as the stable
  // level without an edge, so a button held across reset gives no event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      fill_q   <= '0;
      armed_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      rise_q <= 1'b0;
      if (!armed_q) begin
        cnt_q <= '0;
        if (fill_q[1]) begin
          stable_q <= s2_q;
          armed_q  <= 1'b1;
        end
      end else if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= s2_q;
        cnt_q    <= '0;
        rise_q   <= s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/value_entry.sv
// value_entry: assembles a hex or binary operand from debounced key presses
// and holds it for a consumer until acknowledged.
//   clk, rst_n           - clock, asynchronous active-low reset
//   key_code             - digit value presented with key_btn
//   key_btn/enter_btn/clear_btn - raw buttons, active-high
//   EntrySelect          - 1 = hex entry, 0 = binary entry
//   value, digit_count   - operand and number of accepted digits
//   overflow             - a digit was rejected at the digit limit
//   value_valid          - committed operand held (HOLD state)
//   value_ack            - consumer acknowledge
module value_entry
  import value_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned VALUE_W         = VALUE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         key_code,
  input  logic               key_btn,
  input  logic               enter_btn,
  input  logic               clear_btn,
  input  logic               EntrySelect,
  output logic [VALUE_W-1:0] value,
  output logic [3:0]         digit_count,
  output logic               overflow,
  output logic               value_valid,
  input  logic               value_ack
);

  logic key_ev, enter_ev, clear_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(key_btn), .rise_o(key_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(enter_btn), .rise_o(enter_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(clear_btn), .rise_o(clear_ev)
  );

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [3:0]         count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               sel_q;

  logic               sel_changed;
  logic [3:0]         limit;
  logic               digit_ok;
  logic [VALUE_W-1:0] shifted;
  logic               zero_all;

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    zero_all    = 1'b0;
    sel_changed = (EntrySelect != sel_q);
    limit       = EntrySelect ? 4'(HEX_DIGIT_LIMIT) : 4'(VALUE_W);
    // Binary keys above 1 are dropped entirely, before the limit check.
    digit_ok    = EntrySelect || (key_code <= 4'd1);
    shifted     = EntrySelect ? {value_q[VALUE_W-5:0], key_code}
                              : {value_q[VALUE_W-2:0], key_code[0]};

    if (clear_ev) begin
      zero_all = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if ((state_q == ST_ENTRY) && sel_changed) begin
            zero_all = 1'b1;
          end else if (enter_ev) begin
            if (state_q == ST_ENTRY) state_d = ST_HOLD;
          end else if (key_ev && digit_ok) begin
            state_d = ST_ENTRY;
            if (count_q >= limit) begin
              ovf_d = 1'b1;
            end else begin
              value_d = shifted;
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (value_ack) zero_all = 1'b1;
        end
        default: zero_all = 1'b1;
      endcase
    end

    if (zero_all) begin
      state_d = ST_IDLE;
      value_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      sel_q   <= EntrySelect;
    end
  end

  assign value       = value_q;
  assign digit_count = count_q;
  assign overflow    = ovf_q;
  assign value_valid = (state_q == ST_HOLD);

endmodule

// File: tb/tb_value_entry.sv
// Directed bench for value_entry with hand-computed expectations.
module tb_value_entry;

  localparam int D = 4;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   key_code;
  logic         key_btn, enter_btn, clear_btn, EntrySelect, value_ack;
  logic [W-1:0] value;
  logic [3:0]   digit_count;
  logic         overflow, value_valid;

  int errors = 0;
  int checks = 0;

  value_entry #(.DEBOUNCE_CYCLES(D), .VALUE_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_btn(key_btn),
    .enter_btn(enter_btn), .clear_btn(clear_btn), .EntrySelect(EntrySelect),
    .value(value), .digit_count(digit_count), .overflow(overflow),
    .value_valid(value_valid), .value_ack(value_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] code);
    key_code = code;
    key_btn  = 1'b1;
    cycles(D + 4);
    key_btn  = 1'b0;
    cycles(D + 4);
  endtask

  task automatic press_enter();
    enter_btn = 1'b1;
    cycles(D + 4);
    enter_btn = 1'b0;
    cycles(D + 4);
  endtask

  task automatic press_clear();
    clear_btn = 1'b1;
    cycles(D + 4);
    clear_btn = 1'b0;
    cycles(D + 4);
  endtask

  initial begin
    rst_n = 1'b0; key_code = '0; key_btn = 1'b0; enter_btn = 1'b0;
    clear_btn = 1'b0; EntrySelect = 1'b1; value_ack = 1'b0;
    cycles(3);
    check("rst_value", 32'(value), 0);
    check("rst_count", 32'(digit_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_valid", 32'(value_valid), 0);
    rst_n = 1'b1;
    cycles(5);

    // Button-to-value latency: 2 sync + D debounce + 1 update edges
    key_code = 4'h2;
    key_btn  = 1'b1;
    cycles(2 + D);
    check("lat_before", 32'(value), 0);
    cycles(1);
    check("lat_after", 32'(value), 32'h2);
    cycles(2);
    key_btn = 1'b0;
    cycles(D + 4);

    // Hex entry and commit
    press_key(4'hA);
    press_key(4'h3);
    press_key(4'hF);
    check("hex_value", 32'(value), 32'h2A3F);
    check("hex_count", 32'(digit_count), 4);
    check("hex_valid_pre", 32'(value_valid), 0);
    press_enter();
    check("hold_valid", 32'(value_valid), 1);
    check("hold_value", 32'(value), 32'h2A3F);
    check("hold_count", 32'(digit_count), 4);
    press_key(4'h7);
    check("hold_key_ign", 32'(value), 32'h2A3F);
    check("hold_key_cnt", 32'(digit_count), 4);
    press_enter();
    check("hold_enter_ign", 32'(value_valid), 1);
    EntrySelect = 1'b0;
    cycles(2);
    check("hold_sel_value", 32'(value), 32'h2A3F);
    check("hold_sel_valid", 32'(value_valid), 1);
    EntrySelect = 1'b1;
    cycles(2);
    value_ack = 1'b1;
    cycles(1);
    value_ack = 1'b0;
    check("ack_value", 32'(value), 0);
    check("ack_count", 32'(digit_count), 0);
    check("ack_valid", 32'(value_valid), 0);
    check("ack_ovf", 32'(overflow), 0);

    // Acknowledge outside HOLD is ignored; clear zeroes
    press_key(4'h1);
    value_ack = 1'b1;
    cycles(1);
    value_ack = 1'b0;
    cycles(1);
    check("ack_entry_value", 32'(value), 32'h1);
    check("ack_entry_count", 32'(digit_count), 1);
    press_clear();
    check("clr_value", 32'(value), 0);
    check("clr_count", 32'(digit_count), 0);

    // Hex overflow at 4 digits
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    check("ovf_pre", 32'(overflow), 0);
    press_key(4'h5);
    check("ovf_value", 32'(value), 32'h1234);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(digit_count), 4);
    press_clear();
    check("ovf_clr_flag", 32'(overflow), 0);
    check("ovf_clr_value", 32'(value), 0);

    // Enter with no digits is ignored
    press_enter();
    check("idle_enter", 32'(value_valid), 0);

    // Binary entry, key 9 ignored
    EntrySelect = 1'b0;
    cycles(2);
    press_key(4'h1);
    press_key(4'h0);
    press_key(4'h1);
    press_key(4'h9);
    press_key(4'h1);
    check("bin_value", 32'(value), 32'hB);
    check("bin_count", 32'(digit_count), 4);
    press_clear();

    // Bouncy key press yields one digit
    EntrySelect = 1'b1;
    cycles(2);
    key_code = 4'h3;
    key_btn = 1'b1; cycles(1);
    key_btn = 1'b0; cycles(1);
    key_btn = 1'b1; cycles(1);
    cycles(D + 2);
    key_btn = 1'b0;
    cycles(D + 6);
    check("bounce_count", 32'(digit_count), 1);
    check("bounce_value", 32'(value), 32'h3);

    // Clear beats enter in the same cycle
    clear_btn = 1'b1;
    enter_btn = 1'b1;
    cycles(D + 4);
    clear_btn = 1'b0;
    enter_btn = 1'b0;
    cycles(D + 4);
    check("prio_valid", 32'(value_valid), 0);
    check("prio_value", 32'(value), 0);
    check("prio_count", 32'(digit_count), 0);

    // Mode flip mid-entry clears
    press_key(4'h6);
    check("flip_pre", 32'(value), 32'h6);
    EntrySelect = 1'b0;
    cycles(1);
    check("flip_value", 32'(value), 0);
    check("flip_count", 32'(digit_count), 0);

    // Reset during HOLD, key held across reset release
    press_key(4'h1);
    press_enter();
    check("rh_valid_pre", 32'(value_valid), 1);
    key_code = 4'h1;
    key_btn  = 1'b1;
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("rh_async_valid", 32'(value_valid), 0);
    check("rh_async_value", 32'(value), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3 * D + 6);
    check("rh_held_value", 32'(value), 0);
    check("rh_held_count", 32'(digit_count), 0);
    key_btn = 1'b0;
    cycles(D + 4);
    check("rh_release_count", 32'(digit_count), 0);
    press_key(4'h1);
    check("rh_after_value", 32'(value), 32'h1);
    check("rh_after_count", 32'(digit_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
